led_pulse_stretcher: RTL and testbench
======================================

# led_pulse_stretcher

Output-side counterpart of the button input chain. It converts single-cycle event pulses from core logic into LED drive levels that a person can see. Each channel holds its LED on for a programmable number of prescaler ticks, then forces a minimum off gap. Pulses that arrive while a channel is busy are queued once, so back-to-back events show as separate blinks. It sits between status/event logic and the board LED pins.

## Interface
- WIDTH, 1: number of independent LED channels.
- TICK_CNT_MAX, 25000: prescaler period in clk cycles; must be ≥ 2.
- HOLD_TICKS, 150: on-time in ticks; must be ≥ 1.
- GAP_TICKS, 50: forced off-time in ticks; must be ≥ 1.
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- in  input  WIDTH  synchronous event pulses, one bit per channel. Any cycle with in[i]=1 is an event.
- out  output  WIDTH  registered LED drive, 1 = LED on.
- busy  output  WIDTH  registered; 1 while channel i is in ON or GAP.

## Operation
- **Shared prescaler**
  - tick_cnt counts 0..TICK_CNT_MAX-1, then wraps to 0.
  - tick is a one-cycle strobe, asserted when tick_cnt == TICK_CNT_MAX-1.
  - The prescaler free-runs. It is never restarted by channel activity.
- **Per-channel FSM states:** IDLE, ON, GAP. Each channel also has a remaining counter `rem` and a 1-bit flag `pending`.
- **IDLE**
  - out=0, busy=0.
  - in[i]=1 → ON, rem←HOLD_TICKS, pending←0.
- **ON**
  - out=1, busy=1.
  - On tick: if rem==1, go to GAP with rem←GAP_TICKS; otherwise rem←rem-1.
  - in[i]=1 sets pending.
- **GAP**
  - out=0, busy=1.
  - On tick with rem==1: if (pending | in[i]) go to ON with rem←HOLD_TICKS and pending←0; otherwise go to IDLE.
  - On tick with rem≠1: rem←rem-1.
  - in[i]=1 sets pending.
- **Coalescing:** any number of events during one ON+GAP window collapse into a single queued blink. Nothing else is counted or reported.
- **Simultaneous events**
  - in[i]=1 in the same cycle as ON→GAP: pending is set.
  - in[i]=1 in the same cycle as the GAP exit: the channel goes to ON, exactly as if pending were set.
- **Channel independence:** channels are fully independent apart from the shared tick.
- **Widths**
  - tick_cnt: $clog2(TICK_CNT_MAX) bits.
  - rem: $clog2(max(HOLD_TICKS,GAP_TICKS)+1) bits.
  - Counters never underflow, because every state exits at rem==1.

## Timing
- **Reset:** while rst_n=0, tick_cnt=0, every channel is IDLE, rem=0, pending=0, out=0, busy=0. Reset asserted mid-blink drops out to 0 immediately (asynchronously). Nothing is retained.
- **Reset release:** the first tick occurs TICK_CNT_MAX-1 clk edges after the first active edge.
- **Input latency:** in[i] sampled at edge k → out[i]=1 and busy[i]=1 from edge k+1.
- **On-time:** tick-quantized, between (HOLD_TICKS-1)·TICK_CNT_MAX+1 and HOLD_TICKS·TICK_CNT_MAX cycles.
- **Gap time:** the same rule applies with GAP_TICKS.
- **Outputs:** out and busy change only on clk edges, or on rst_n assertion. They are glitch-free and suitable for direct pin drive.

## Structure
- **Package led_stretch_pkg:**
  - state enum {ST_IDLE, ST_ON, ST_GAP}, 2 bits.
  - Width helper function for rem sizing.
- **Sub-module led_stretch_channel:**
  - Contains one FSM, rem and pending.
  - Inputs: clk, rst_n, tick, in_bit.
  - Outputs: out_bit, busy_bit.
- **Top:** owns the prescaler and instantiates WIDTH channels in a generate loop.

## Test plan
All scenarios use TICK_CNT_MAX=4, HOLD_TICKS=3, GAP_TICKS=2, and number edges from the first edge after reset release as 0, so ticks occur at edges 3, 7, 11, 15, 19, ...

- **Single pulse:** in[0]=1 at edge 1 → out[0]=1 over edges 2..11 and 0 from edge 12; busy[0]=1 over edges 2..19 and 0 from edge 20.
- **Queued pulse:** in[0] pulses at 1 and again at 5 → first blink as above; a second ON starts at edge 20 (out=1 edges 20..31), then GAP, then IDLE with busy=0 from edge 40.
- **Coalescing:** pulses at 1, 5, 9 and 14 → exactly two blinks, identical to the queued-pulse scenario.
- **Boundary events:**
  - Pulse exactly at edge 11 (the ON→GAP tick) → pending set, second blink from edge 20.
  - Pulse exactly at edge 19 (the GAP exit, pending=0) → ON from edge 20.
- **Reset mid-blink:** rst_n=0 at edge 6 → out/busy=0 immediately. After release a new pulse gives a fresh full blink, with the tick phase restarted from 0.
- **Independence:** WIDTH=2, in[0] pulse at 1, in[1] pulse at 8 → out[1] rises at edge 9 and falls at edge 20; out[0] matches the single-pulse scenario.

Source files
------------

// File: rtl/led_pulse_stretcher_pkg.sv
// Shared types and sizing helpers for the LED pulse stretcher.
// Provides the per-channel state encoding and the width rule for the remaining-ticks counter.
package led_stretch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Counter must hold the larger of the two reload values.
  function automatic int rem_width(input int hold_ticks, input int gap_ticks);
    int max_v;
    int w;
    max_v = (hold_ticks > gap_ticks) ? hold_ticks : gap_ticks;
    w     = $clog2(max_v + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/led_pulse_stretcher_if.sv
// Event-in / LED-out bundle between core logic and the pulse stretcher.
// The slave side is the stretcher; the master side is the event source and the pin driver.
interface led_pulse_stretcher_if #(
  parameter int WIDTH = 1
) ();

  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] busy;

  modport master (
    output in,
    input  out,
    input  busy
  );

  modport slave (
    input  in,
    output out,
    output busy
  );

endinterface

// File: rtl/led_pulse_stretcher_channel.sv
// One LED channel: hold on for HOLD_TICKS, force off for GAP_TICKS, and queue
// at most one further blink for events arriving while busy.
module led_stretch_channel
  import led_stretch_pkg::*;
#(
  parameter int HOLD_TICKS = 150,
  parameter int GAP_TICKS  = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic in_bit_i,
  output logic out_bit_o,
  output logic busy_bit_o
);

  localparam int RW = rem_width(HOLD_TICKS, GAP_TICKS);

  localparam logic [RW-1:0] HOLD_RELOAD = RW'(HOLD_TICKS);
  localparam logic [RW-1:0] GAP_RELOAD  = RW'(GAP_TICKS);
  localparam logic [RW-1:0] REM_ONE     = RW'(1);

  state_e        state_q;
  state_e        state_d;
  logic [RW-1:0] rem_q;
  logic [RW-1:0] rem_d;
  logic          pending_q;
  logic          pending_d;
  logic          out_q;
  logic          busy_q;

  // State, counter and queued-event registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      pending_q <= pending_d;
    end
  end

  // Next-state logic; every state leaves at rem==1 so rem never underflows.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    pending_d = pending_q;
    case (state_q)
      ST_IDLE: begin
        if (in_bit_i) begin
          state_d   = ST_ON;
          rem_d     = HOLD_RELOAD;
          pending_d = 1'b0;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_ON: begin
        pending_d = pending_q | in_bit_i;
        if (tick_i) begin
          if (rem_q == REM_ONE) begin
            state_d = ST_GAP;
            rem_d   = GAP_RELOAD;
          end else begin
            rem_d   = rem_q - REM_ONE;
          end
        end else begin
          rem_d = rem_q;
        end
      end
      ST_GAP: begin
        pending_d = pending_q | in_bit_i;
        if (tick_i) begin
          if (rem_q == REM_ONE) begin
            // An event on the exit cycle counts the same as a queued one.
            if (pending_q || in_bit_i) begin
              state_d   = ST_ON;
              rem_d     = HOLD_RELOAD;
              pending_d = 1'b0;
            end else begin
              state_d   = ST_IDLE;
              rem_d     = '0;
              pending_d = 1'b0;
            end
          end else begin
            rem_d = rem_q - REM_ONE;
          end
        end else begin
          rem_d = rem_q;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        rem_d     = '0;
        pending_d = 1'b0;
      end
    endcase
  end

  // Pin drivers come straight from flops so they cannot glitch on state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      out_q  <= (state_q == ST_ON);
      busy_q <= (state_q != ST_IDLE);
    end
  end

  assign out_bit_o  = out_q;
  assign busy_bit_o = busy_q;

endmodule

// File: rtl/led_pulse_stretcher.sv
// LED pulse stretcher top: one free-running prescaler shared by WIDTH
// independent stretcher channels.
module led_pulse_stretcher #(
  parameter int WIDTH        = 1,
  parameter int TICK_CNT_MAX = 25000,
  parameter int HOLD_TICKS   = 150,
  parameter int GAP_TICKS    = 50
) (
  input  logic                  clk,
  input  logic                  rst_n,
  led_pulse_stretcher_if.slave  bus_if
);

  localparam int TW = (TICK_CNT_MAX > 1) ? $clog2(TICK_CNT_MAX) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CNT_MAX - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);

  logic [TW-1:0]    tick_cnt_q;
  logic [TW-1:0]    tick_cnt_d;
  logic             tick_s;
  logic [WIDTH-1:0] out_s;
  logic [WIDTH-1:0] busy_s;

  assign tick_s = (tick_cnt_q == TICK_LAST);

  // Prescaler next value; wraps on the tick cycle and ignores channel activity.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (tick_s) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + TICK_ONE;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    led_stretch_channel #(
      .HOLD_TICKS (HOLD_TICKS),
      .GAP_TICKS  (GAP_TICKS)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick_i     (tick_s),
      .in_bit_i   (bus_if.in[g]),
      .out_bit_o  (out_s[g]),
      .busy_bit_o (busy_s[g])
    );
  end

  assign bus_if.out  = out_s;
  assign bus_if.busy = busy_s;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Self-checking bench for led_pulse_stretcher with TICK_CNT_MAX=4, HOLD=3, GAP=2, WIDTH=2.
// Expected per-edge {busy,out} words are queued as stimulus is driven and popped after each edge.
module tb_led_pulse_stretcher;

  localparam int W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;
  logic [3:0] exp_q[$];

  led_pulse_stretcher_if #(.WIDTH(W)) bus_if ();

  led_pulse_stretcher #(
    .WIDTH        (W),
    .TICK_CNT_MAX (4),
    .HOLD_TICKS   (3),
    .GAP_TICKS    (2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got busy/out=%b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic in_iv(input int e, input int a, input int b);
    return (a >= 0) && (e >= a) && (e <= b);
  endfunction

  // Ends on a negedge with rst_n released, so the next posedge is edge 0.
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus_if.in = '0;
    repeat (2) @(negedge clk);
    check_val("reset_state", {bus_if.busy, bus_if.out}, 4'b0000);
    rst_n = 1'b1;
  endtask

  // o0a..o0d: ch0 on-intervals, b0a/b0b: ch0 busy interval, o1/b1: ch1 intervals (-1 = none).
  task automatic run_edges(input string name, input logic [63:0] m0, input logic [63:0] m1,
                           input int n, input int o0a, input int o0b, input int o0c, input int o0d,
                           input int b0a, input int b0b, input int o1a, input int o1b,
                           input int b1a, input int b1b);
    logic [3:0] got;
    for (int e = 0; e < n; e++) begin
      bus_if.in = {m1[e], m0[e]};
      exp_q.push_back({in_iv(e, b1a, b1b), in_iv(e, b0a, b0b),
                       in_iv(e, o1a, o1b), in_iv(e, o0a, o0b) | in_iv(e, o0c, o0d)});
      @(posedge clk);
      #1;
      got = {bus_if.busy, bus_if.out};
      check_val($sformatf("%s@e%0d", name, e), got, exp_q.pop_front());
      @(negedge clk);
    end
    bus_if.in = '0;
  endtask

  initial begin
    bus_if.in = '0;

    apply_reset();
    run_edges("single", 64'h2, 64'h0, 24, 2, 11, -1, -1, 2, 19, -1, -1, -1, -1);

    apply_reset();
    run_edges("queued", 64'h22, 64'h0, 44, 2, 11, 20, 31, 2, 39, -1, -1, -1, -1);

    apply_reset();
    run_edges("coalesce", 64'h4222, 64'h0, 44, 2, 11, 20, 31, 2, 39, -1, -1, -1, -1);

    apply_reset();
    run_edges("evt_at_on_exit", 64'h802, 64'h0, 44, 2, 11, 20, 31, 2, 39, -1, -1, -1, -1);

    apply_reset();
    run_edges("evt_at_gap_exit", 64'h80002, 64'h0, 44, 2, 11, 20, 31, 2, 39, -1, -1, -1, -1);

    apply_reset();
    run_edges("indep", 64'h2, 64'h100, 32, 2, 11, -1, -1, 2, 19, 9, 19, 9, 27);

    apply_reset();
    run_edges("pre_rst", 64'h2, 64'h0, 7, 2, 11, -1, -1, 2, 19, -1, -1, -1, -1);
    rst_n = 1'b0;
    #1;
    check_val("async_rst_clear", {bus_if.busy, bus_if.out}, 4'b0000);

    apply_reset();
    run_edges("post_rst", 64'h2, 64'h0, 24, 2, 11, -1, -1, 2, 19, -1, -1, -1, -1);

    check_val("scoreboard_drained", 4'(exp_q.size()), 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
